// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory (0x1001_xxxx window) between
// the CPU MEM stage and a DMA block-transfer engine. Each access is sequenced
// through ISSUE/WAIT/DONE and answered with a one-cycle ack. CPU has fixed
// priority; DMA overrides once it has waited STARVE_LIM cycles.
//
// Optional feature: define DMEM_ARB_PERF_EN to build the perf_conflict counter
// (cycles a CPU request is blocked by DMA). Without it perf_conflict is tied 0.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight; grant evaluated every cycle
// ISSUE | command on the memory bus (mem_en) or window error detected
// WAIT  | read latency countdown; mem_rdata captured on the last cycle
// DONE  | owner's ack pulses with captured rdata / err
module dmem_arbiter #(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_LIM = 8,
  parameter logic [15:0] BASE_HI    = 16'h1001,
  parameter logic [2:0]  DMA_LEN    = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_len,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [2:0]  mem_len,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [15:0] perf_conflict
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // WAIT is entered after the ISSUE cycle, so it lasts RD_LAT-1 more cycles
  // past the first WAIT cycle before the terminal count.
  localparam logic [2:0] LAT_LOAD   = 3'(RD_LAT - 1);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIM);

  logic [1:0]  state;
  logic        own_dma;
  logic        cmd_we;
  logic        cmd_err;
  logic [2:0]  lat_cnt;
  logic [7:0]  dma_wait;

  logic        grant_cpu;
  logic        grant_dma;
  logic        sel_we;
  logic [2:0]  sel_len;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_in_win;
  logic        finish;
  logic [31:0] fin_data;
  logic        dma_owns;

  // Grant decision in IDLE: starved DMA first, then CPU, then DMA.
  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (state == S_IDLE) begin
      if (dma_req && (dma_wait == STARVE_MAX)) begin
        grant_dma = 1'b1;
      end else if (cpu_req) begin
        grant_cpu = 1'b1;
      end else if (dma_req) begin
        grant_dma = 1'b1;
      end
    end
  end

  // Command selected from the winning requester, plus window check.
  always_comb begin
    sel_we     = grant_dma ? dma_we    : cpu_we;
    sel_len    = grant_dma ? DMA_LEN   : cpu_len;
    sel_addr   = grant_dma ? dma_addr  : cpu_addr;
    sel_wdata  = grant_dma ? dma_wdata : cpu_wdata;
    sel_in_win = (sel_addr[31:16] == BASE_HI);
  end

  // Completion strobe: writes/errors finish out of ISSUE, reads at terminal count.
  always_comb begin
    finish   = ((state == S_ISSUE) && (cmd_err || cmd_we)) ||
               ((state == S_WAIT) && (lat_cnt == 3'd0));
    fin_data = (state == S_WAIT) ? mem_rdata : 32'h0;
    dma_owns = (state != S_IDLE) && own_dma;
  end

  assign cpu_stall = cpu_req & ~cpu_ack;

  // Access sequencer and latched command / memory bus drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      own_dma   <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_err   <= 1'b0;
      lat_cnt   <= 3'd0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_len   <= 3'd0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_cpu || grant_dma) begin
            own_dma   <= grant_dma;
            cmd_we    <= sel_we;
            cmd_err   <= ~sel_in_win;
            mem_len   <= sel_len;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_en    <= sel_in_win;
            mem_we    <= sel_in_win & sel_we;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (cmd_err || cmd_we) begin
            state <= S_DONE;
          end else begin
            lat_cnt <= LAT_LOAD;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == 3'd0) begin
            state <= S_DONE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Owner response: ack pulses once, rdata/err hold until the next ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_ack   <= 1'b0;
      cpu_rdata <= 32'h0;
      cpu_err   <= 1'b0;
      dma_ack   <= 1'b0;
      dma_rdata <= 32'h0;
      dma_err   <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      if (finish) begin
        if (own_dma) begin
          dma_ack   <= 1'b1;
          dma_rdata <= fin_data;
          dma_err   <= cmd_err;
        end else begin
          cpu_ack   <= 1'b1;
          cpu_rdata <= fin_data;
          cpu_err   <= cmd_err;
        end
      end
    end
  end

  // DMA starvation counter: counts blocked DMA cycles, cleared on DMA grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dma_wait <= 8'd0;
    end else if (grant_dma) begin
      dma_wait <= 8'd0;
    end else if (dma_req && !dma_owns && (dma_wait != STARVE_MAX)) begin
      dma_wait <= dma_wait + 8'd1;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] perf_cnt;

  // Saturating count of cycles a CPU request is blocked by DMA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt <= 16'h0;
    end else if (cpu_req && (dma_owns || grant_dma) && (perf_cnt != 16'hFFFF)) begin
      perf_cnt <= perf_cnt + 16'h1;
    end
  end

  assign perf_conflict = perf_cnt;
`else
  assign perf_conflict = 16'h0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed accesses with hand-computed responses pushed
// into scoreboard queues; a negedge monitor pops and compares on every ack and
// every mem_en strobe.
module tb_dmem_arbiter;

  localparam int RD_LAT = 1;

  typedef struct {
    bit          port;   // 0 = CPU, 1 = DMA
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [2:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [2:0]  cpu_len = 3'd0;
  logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
  logic        cpu_ack, cpu_err, cpu_stall;
  logic [31:0] cpu_rdata;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = 32'h0, dma_wdata = 32'h0;
  logic        dma_ack, dma_err;
  logic [31:0] dma_rdata;
  logic        mem_en, mem_we;
  logic [2:0]  mem_len;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] perf_conflict;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  rsp_t rsp_q[$];
  cmd_t cmd_q[$];

  logic [31:0] mem_store [256];
  logic [31:0] rd_pipe [RD_LAT];

  dmem_arbiter #(
    .RD_LAT(RD_LAT), .STARVE_LIM(8), .BASE_HI(16'h1001), .DMA_LEN(3'd4)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_len(cpu_len), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cpu_err(cpu_err), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .perf_conflict(perf_conflict)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data appears RD_LAT cycles after mem_en, junk otherwise.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem_store[mem_addr[9:2]] <= mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we) ? mem_store[mem_addr[9:2]] : 32'hBAD0_BAD0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_rsp(input bit port, input logic [31:0] rdata, input logic err);
    rsp_t e;
    checks++;
    if (rsp_q.size() == 0) begin
      errors++;
      $display("FAIL ack_unexpected: port=%0d at cyc=%0d, none expected", port, cyc);
    end else begin
      e = rsp_q.pop_front();
      if (e.port != port || e.cyc != cyc || e.rdata !== rdata || e.err !== err) begin
        errors++;
        $display("FAIL ack: got port=%0d cyc=%0d rdata=%h err=%b expected port=%0d cyc=%0d rdata=%h err=%b",
                 port, cyc, rdata, err, e.port, e.cyc, e.rdata, e.err);
      end
    end
  endtask

  task automatic check_cmd();
    cmd_t e;
    checks++;
    if (cmd_q.size() == 0) begin
      errors++;
      $display("FAIL mem_en_unexpected: addr=%h at cyc=%0d, none expected", mem_addr, cyc);
    end else begin
      e = cmd_q.pop_front();
      if (e.we !== mem_we || e.len !== mem_len || e.addr !== mem_addr || e.wdata !== mem_wdata) begin
        errors++;
        $display("FAIL mem_cmd: got we=%b len=%0d addr=%h wdata=%h expected we=%b len=%0d addr=%h wdata=%h",
                 mem_we, mem_len, mem_addr, mem_wdata, e.we, e.len, e.addr, e.wdata);
      end
    end
  endtask

  // Monitor: every ack and every memory strobe is matched against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_ack) check_rsp(1'b0, cpu_rdata, cpu_err);
      if (dma_ack) check_rsp(1'b1, dma_rdata, dma_err);
      if (mem_en)  check_cmd();
    end
  end

  task automatic push_rsp(input bit port, input int c, input logic [31:0] rdata, input logic err);
    rsp_t e;
    e.port = port; e.cyc = c; e.rdata = rdata; e.err = err;
    rsp_q.push_back(e);
  endtask

  task automatic push_cmd(input logic we, input logic [2:0] len, input logic [31:0] addr,
                          input logic [31:0] wdata);
    cmd_t e;
    e.we = we; e.len = len; e.addr = addr; e.wdata = wdata;
    cmd_q.push_back(e);
  endtask

  // Single access: raise req, hold until ack (bounded), then drop.
  task automatic access(input bit port, input logic we, input logic [2:0] len,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    int n;
    bit seen;
    @(posedge clk); #1;
    n = cyc;
    push_rsp(port, n + lat, exp_rdata, exp_err);
    if (!exp_err) push_cmd(we, port ? 3'd4 : len, addr, wdata);
    if (port) begin
      dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
    end else begin
      cpu_we = we; cpu_len = len; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (!port) check("cpu_stall", {31'h0, cpu_stall}, {31'h0, (cyc < n + lat)});
      seen = port ? dma_ack : cpu_ack;
    end
    if (!seen) check("ack_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    if (port) dma_req = 1'b0; else cpu_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, {25'h0, cpu_ack, cpu_err, cpu_stall, dma_ack, dma_err, mem_en, mem_we},
          32'h0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
    check({tag, "_dma_rdata"}, dma_rdata, 32'h0);
    check({tag, "_mem_len"}, {29'h0, mem_len}, 32'h0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check({tag, "_perf"}, {16'h0, perf_conflict}, 32'h0);
  endtask

  initial begin
    int n0;
    int cpu_cnt;
    bit ack_c, ack_d;

    for (int i = 0; i < 256; i++) mem_store[i] = 32'h0;
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = 32'h0;

    // Reset state
    @(negedge clk);
    check_all_zero("rst0");
    @(posedge clk); #1;
    rst = 1'b0;

    // CPU write then DMA write/read, CPU read back
    access(1'b0, 1'b1, 3'd2, 32'h1001_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    access(1'b1, 1'b1, 3'd0, 32'h1001_0100, 32'h1234_5678, 32'h0, 1'b0, 2);
    access(1'b1, 1'b0, 3'd0, 32'h1001_0100, 32'hCAFE_0001, 32'h1234_5678, 1'b0, 2 + RD_LAT);
    access(1'b0, 1'b0, 3'd2, 32'h1001_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 2 + RD_LAT);

    // Reset in WAIT of a CPU read: access abandoned, no ack, outputs cleared
    @(posedge clk); #1;
    push_cmd(1'b0, 3'd2, 32'h1001_0010, 32'h5555_AAAA);
    cpu_we = 1'b0; cpu_len = 3'd2; cpu_addr = 32'h1001_0010; cpu_wdata = 32'h5555_AAAA;
    cpu_req = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid");
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Fresh read after reset, then held rdata, then window errors
    access(1'b0, 1'b0, 3'd2, 32'h1001_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 2 + RD_LAT);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("cpu_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);
    access(1'b0, 1'b0, 3'd2, 32'h0008_0000, 32'h0, 32'h0, 1'b1, 2);
    access(1'b1, 1'b1, 3'd0, 32'h2000_0000, 32'h7777_7777, 32'h0, 1'b1, 2);

    // Both requesters held: CPU x3, starved DMA, then CPU
    @(posedge clk); #1;
    n0 = cyc;
    for (int i = 0; i < 3; i++) begin
      push_rsp(1'b0, n0 + 2 + 3 * i, 32'h0, 1'b0);
      push_cmd(1'b1, 3'd2, 32'h1001_0200 + 32'(4 * i), 32'hA000_0000 + 32'(i));
    end
    push_rsp(1'b1, n0 + 11, 32'h0, 1'b0);
    push_cmd(1'b1, 3'd4, 32'h1001_0300, 32'h0D0D_0D0D);
    push_rsp(1'b0, n0 + 14, 32'h0, 1'b0);
    push_cmd(1'b1, 3'd2, 32'h1001_020C, 32'hA000_0003);
    cpu_we = 1'b1; cpu_len = 3'd2; cpu_addr = 32'h1001_0200; cpu_wdata = 32'hA000_0000;
    dma_we = 1'b1; dma_addr = 32'h1001_0300; dma_wdata = 32'h0D0D_0D0D;
    cpu_req = 1'b1;
    dma_req = 1'b1;
    cpu_cnt = 0;
    for (int k = 0; k < 60 && (cpu_req || dma_req); k++) begin
      @(negedge clk);
      if (cyc == n0 + 10) check("stall_under_dma", {31'h0, cpu_stall}, 32'h1);
      ack_c = cpu_ack;
      ack_d = dma_ack;
      @(posedge clk); #1;
      if (ack_c) begin
        cpu_cnt++;
        if (cpu_cnt == 4) begin
          cpu_req = 1'b0;
        end else begin
          cpu_addr  = 32'h1001_0200 + 32'(4 * cpu_cnt);
          cpu_wdata = 32'hA000_0000 + 32'(cpu_cnt);
        end
      end
      if (ack_d) dma_req = 1'b0;
    end
    check("arb_done", {30'h0, cpu_req, dma_req}, 32'h0);
    cpu_req = 1'b0;
    dma_req = 1'b0;

    repeat (5) @(posedge clk);
    @(negedge clk);
`ifdef DMEM_ARB_PERF_EN
    check("perf_conflict", {16'h0, perf_conflict}, 32'd3);
`else
    check("perf_conflict", {16'h0, perf_conflict}, 32'd0);
`endif
    check("rsp_q_drained", rsp_q.size(), 32'd0);
    check("cmd_q_drained", cmd_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
